// File: rtl/rfg_tmr_pkg.sv
// Shared types and helpers for the TMR register-file byte front end.
package rfg_tmr_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_DATA   = 2'd1,
        WR_COMMIT = 2'd2,
        RD_DATA   = 2'd3
    } seq_state_t;

    localparam int HDR_WRITE_BIT = 7;
    localparam int HDR_ADDR_MSB  = 6;

    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/rfg_byte_shifter.sv
// Byte-wide shift register: assembles LSB-first bytes in, or serialises a loaded word out.
module rfg_byte_shifter
    import rfg_tmr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             shift_in,
    input  logic [7:0]       in_byte,
    input  logic             shift_out,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_next,
    output logic [7:0]       out_byte,
    output logic             last
);
    localparam int NB = nbytes(WIDTH);
    localparam int PW = NB * 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [PW-1:0] data;
    logic [PW-1:0] data_in_next;
    logic [PW-1:0] load_ext;
    logic [CW-1:0] count;

    // New bytes enter at the top so that after NB shifts byte 0 sits in bits [7:0].
    always_comb begin
        data_in_next = data >> 8;
        data_in_next[PW-1 -: 8] = in_byte;
    end

    always_comb begin
        load_ext = '0;
        load_ext[WIDTH-1:0] = load_value;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            data  <= '0;
            count <= '0;
        end else if (clear) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_ext;
            count <= '0;
        end else if (shift_in) begin
            data  <= data_in_next;
            count <= last ? '0 : count + 1'b1;
        end else if (shift_out) begin
            data  <= data >> 8;
            count <= last ? '0 : count + 1'b1;
        end
    end

    assign value      = data[WIDTH-1:0];
    assign value_next = data_in_next[WIDTH-1:0];
    assign out_byte   = data[7:0];
    assign last       = (count == CW'(NB - 1));

endmodule

// File: rtl/rfg_tmr_write_sequencer.sv
// Byte-stream command front end for the TMR register bank: header decode,
// write assembly with a one-cycle strobe, and serialised read responses.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   IDLE      | waiting for a header byte
//   WR_DATA   | collecting NBYTES write data bytes, LSB first
//   WR_COMMIT | one cycle: write strobe or address error
//   RD_DATA   | streaming the sampled register value out
module rfg_tmr_write_sequencer
    import rfg_tmr_pkg::*;
#(
    parameter int               NREGS     = 16,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       reg_write_value,
    output logic [NREGS-1:0]       reg_write,
    input  logic [NREGS*WIDTH-1:0] reg_read_values,
    output logic                   err_addr
);
    localparam int AW = HDR_ADDR_MSB + 1;

    seq_state_t state;
    seq_state_t state_nxt;

    logic [AW-1:0]    addr;
    logic [AW-1:0]    hdr_addr;
    logic             hdr_write;
    logic             hdr_hit;
    logic             addr_hit;
    logic             hdr_fire;
    logic             wr_fire;
    logic             rd_fire;
    logic [NREGS-1:0] wr_onehot;
    logic [WIDTH-1:0] rd_sel;

    logic             wr_last;
    logic [WIDTH-1:0] wr_value;
    logic [WIDTH-1:0] wr_value_next;
    logic [7:0]       wr_out_byte;
    logic             rd_last;
    logic [WIDTH-1:0] rd_value;
    logic [WIDTH-1:0] rd_value_next;
    logic [7:0]       rd_out_byte;
    logic             unused_bits;

    assign hdr_addr  = in_data[HDR_ADDR_MSB:0];
    assign hdr_write = in_data[HDR_WRITE_BIT];
    assign hdr_hit   = int'(hdr_addr) < NREGS;
    assign addr_hit  = int'(addr) < NREGS;
    assign hdr_fire  = (state == IDLE) && in_valid;
    assign wr_fire   = (state == WR_DATA) && in_valid;
    assign rd_fire   = out_valid && out_ready;

    always_comb begin
        wr_onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_onehot[i] = (addr == AW'(i));
        end
    end

    // Out-of-range read addresses fall through to zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (hdr_addr == AW'(i)) begin
                rd_sel = reg_read_values[i*WIDTH +: WIDTH];
            end
        end
    end

    rfg_byte_shifter #(.WIDTH(WIDTH)) u_wr_shifter (
        .clk        (clk),
        .res        (res),
        .clear      (hdr_fire),
        .load       (1'b0),
        .load_value ('0),
        .shift_in   (wr_fire),
        .in_byte    (in_data),
        .shift_out  (1'b0),
        .value      (wr_value),
        .value_next (wr_value_next),
        .out_byte   (wr_out_byte),
        .last       (wr_last)
    );

    rfg_byte_shifter #(.WIDTH(WIDTH)) u_rd_shifter (
        .clk        (clk),
        .res        (res),
        .clear      (1'b0),
        .load       (hdr_fire && !hdr_write),
        .load_value (rd_sel),
        .shift_in   (1'b0),
        .in_byte    (8'h00),
        .shift_out  (rd_fire),
        .value      (rd_value),
        .value_next (rd_value_next),
        .out_byte   (rd_out_byte),
        .last       (rd_last)
    );

    assign unused_bits = ^{wr_value, wr_out_byte, rd_value, rd_value_next};

    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = hdr_write ? WR_DATA : RD_DATA;
                end
            end
            WR_DATA: begin
                in_ready = 1'b1;
                if (in_valid && wr_last) begin
                    state_nxt = WR_COMMIT;
                end
            end
            WR_COMMIT: state_nxt = IDLE;
            RD_DATA: begin
                if (out_ready && rd_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe, error and value are registered on the last data byte so they
    // appear exactly during WR_COMMIT.
    always_ff @(posedge clk) begin
        if (res) begin
            addr            <= '0;
            reg_write_value <= RESET_VAL;
            reg_write       <= '0;
            err_addr        <= 1'b0;
            out_valid       <= 1'b0;
        end else begin
            reg_write <= '0;
            err_addr  <= 1'b0;
            if (hdr_fire) begin
                addr <= hdr_addr;
                if (!hdr_write) begin
                    out_valid <= 1'b1;
                    err_addr  <= !hdr_hit;
                end
            end
            if (wr_fire && wr_last) begin
                if (addr_hit) begin
                    reg_write       <= wr_onehot;
                    reg_write_value <= wr_value_next;
                end else begin
                    err_addr <= 1'b1;
                end
            end
            if (rd_fire && rd_last) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_data = rd_out_byte;

endmodule

// File: tb/tb_rfg_tmr_write_sequencer.sv
// Bench for rfg_tmr_write_sequencer: queue-based command model checked every cycle,
// directed scenarios with literal expectations, and randomized command traffic.
module tb_rfg_tmr_write_sequencer;
    localparam int NREGS = 16;
    localparam int WIDTH = 16;
    localparam int NB    = (WIDTH + 7) / 8;
    localparam logic [WIDTH-1:0] RV = 16'h5A5A;

    logic                   clk = 1'b0;
    logic                   res;
    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       reg_write_value;
    logic [NREGS-1:0]       reg_write;
    logic [NREGS*WIDTH-1:0] reg_read_values;
    logic                   err_addr;

    // 12-bit, 4-register instance for the partial-top-byte cases
    logic [7:0]  s_in_data;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_out_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [11:0] s_reg_write_value;
    logic [3:0]  s_reg_write;
    logic [47:0] s_reg_read_values;
    logic        s_err_addr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    rfg_tmr_write_sequencer #(.NREGS(NREGS), .WIDTH(WIDTH), .RESET_VAL(RV)) dut (
        .clk(clk), .res(res), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .reg_write_value(reg_write_value), .reg_write(reg_write),
        .reg_read_values(reg_read_values), .err_addr(err_addr)
    );

    rfg_tmr_write_sequencer #(.NREGS(4), .WIDTH(12), .RESET_VAL(12'h000)) dut12 (
        .clk(clk), .res(res), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .reg_write_value(s_reg_write_value), .reg_write(s_reg_write),
        .reg_read_values(s_reg_read_values), .err_addr(s_err_addr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Command-level model: a queue of received write bytes and a queue of
    // response bytes still owed to the sink.
    bit               m_on = 0;
    bit               m_cmd = 0;
    bit               m_commit = 0;
    int               m_a = 0;
    byte unsigned     m_rx[$];
    byte unsigned     m_tx[$];
    logic [NREGS-1:0] m_wr = '0;
    logic             m_err = 1'b0;
    logic [WIDTH-1:0] m_val = RV;

    function automatic bit m_in_ready();
        return !m_commit && (m_tx.size() == 0);
    endfunction

    always @(posedge clk) begin
        bit rdy;
        longint unsigned v;
        rdy   = m_in_ready();
        m_wr  = '0;
        m_err = 1'b0;
        if (res) begin
            m_on = 1; m_cmd = 0; m_commit = 0;
            m_rx.delete(); m_tx.delete();
            m_val = RV;
        end else if (m_on) begin
            m_commit = 0;
            if (m_tx.size() > 0 && out_ready) void'(m_tx.pop_front());
            if (rdy && in_valid) begin
                if (!m_cmd) begin
                    m_a = int'(in_data[6:0]);
                    if (in_data[7]) begin
                        m_cmd = 1;
                        m_rx.delete();
                    end else begin
                        v = 0;
                        if (m_a < NREGS) v = longint'(reg_read_values[m_a*WIDTH +: WIDTH]);
                        for (int k = 0; k < NB; k++) m_tx.push_back(8'(v >> (8*k)));
                        m_err = (m_a >= NREGS);
                    end
                end else begin
                    m_rx.push_back(in_data);
                    if (m_rx.size() == NB) begin
                        v = 0;
                        for (int k = 0; k < NB; k++) v |= longint'(m_rx[k]) << (8*k);
                        if (m_a < NREGS) begin
                            m_wr[m_a] = 1'b1;
                            m_val = WIDTH'(v);
                        end else begin
                            m_err = 1'b1;
                        end
                        m_cmd = 0;
                        m_commit = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("in_ready", in_ready, m_in_ready());
            chk("out_valid", out_valid, m_tx.size() > 0);
            if (m_tx.size() > 0) chk("out_data", out_data, m_tx[0]);
            chk("reg_write", reg_write, m_wr);
            chk("err_addr", err_addr, m_err);
            chk("reg_write_value", reg_write_value, m_val);
            chk("reg_write_onehot0", $onehot0(reg_write), 1'b1);
        end
    end

    int          strobe_cyc[$];
    logic [15:0] strobe_val[$];
    always @(negedge clk) begin
        if (reg_write != '0) begin
            strobe_cyc.push_back(cyc);
            strobe_val.push_back(reg_write);
        end
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send(input logic [7:0] b, input bit hold = 0);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1'b1);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic s_send(input logic [7:0] b);
        int n = 0;
        s_in_valid = 1'b1;
        s_in_data  = b;
        while (!s_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("s_send_ready", s_in_ready, 1'b1);
        @(negedge clk);
        s_in_valid = 1'b0;
    endtask

    task automatic rand_gap();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        res = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        reg_read_values = '0;
        s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b0; s_reg_read_values = '0;
        repeat (2) @(negedge clk);
        res = 1'b0;

        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_reg_write", reg_write, 16'h0000);
        chk("rst_err_addr", err_addr, 1'b0);
        chk("rst_value", reg_write_value, 16'h5A5A);

        // write 0x1234 to register 3
        send(8'h83); send(8'h34); send(8'h12);
        chk("wr3_strobe", reg_write, 16'h0008);
        chk("wr3_value", reg_write_value, 16'h1234);
        chk("wr3_err", err_addr, 1'b0);
        chk("wr3_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("wr3_strobe_end", reg_write, 16'h0000);
        chk("wr3_idle", in_ready, 1'b1);

        // read slot 5 with a stalled sink
        reg_read_values[5*WIDTH +: WIDTH] = 16'hBEEF;
        send(8'h05);
        for (int i = 0; i < 3; i++) begin
            chk("rd5_stall_valid", out_valid, 1'b1);
            chk("rd5_stall_data", out_data, 8'hEF);
            chk("rd5_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("rd5_byte1_valid", out_valid, 1'b1);
        chk("rd5_byte1_data", out_data, 8'hBE);
        chk("rd5_byte1_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("rd5_done_valid", out_valid, 1'b0);
        chk("rd5_done_in_ready", in_ready, 1'b1);
        out_ready = 1'b0;

        // out-of-range write
        send(8'hFF); send(8'hAA); send(8'hBB);
        chk("bad_wr_strobe", reg_write, 16'h0000);
        chk("bad_wr_err", err_addr, 1'b1);
        chk("bad_wr_value_kept", reg_write_value, 16'h1234);
        @(negedge clk);
        chk("bad_wr_err_end", err_addr, 1'b0);

        // reset after the first data byte
        strobe_cyc.delete(); strobe_val.delete();
        send(8'h82); send(8'h11);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, 8'h00);
        chk("midrst_err", err_addr, 1'b0);
        chk("midrst_value", reg_write_value, 16'h5A5A);
        repeat (3) @(negedge clk);
        chk("midrst_no_strobe", strobe_cyc.size(), 0);
        send(8'h82); send(8'h66); send(8'h77);
        chk("midrst_fresh_strobe", reg_write, 16'h0004);
        chk("midrst_fresh_value", reg_write_value, 16'h7766);

        // back-to-back writes with in_valid held high
        @(negedge clk);
        strobe_cyc.delete(); strobe_val.delete();
        send(8'h81, 1); send(8'h01, 1); send(8'h02, 1);
        send(8'h83, 1); send(8'h03, 1); send(8'h04);
        @(negedge clk);
        chk("b2b_count", strobe_cyc.size(), 2);
        if (strobe_cyc.size() == 2) begin
            chk("b2b_spacing", strobe_cyc[1] - strobe_cyc[0], 4);
            chk("b2b_first", strobe_val[0], 16'h0002);
            chk("b2b_second", strobe_val[1], 16'h0008);
        end

        // 12-bit instance: top nibble of the second byte is dropped
        s_send(8'h81); s_send(8'hCD); s_send(8'hFA);
        chk("w12_strobe", s_reg_write, 4'b0010);
        chk("w12_value", s_reg_write_value, 12'hACD);
        s_reg_read_values[12 +: 12] = 12'hACD;
        s_out_ready = 1'b1;
        s_send(8'h01);
        chk("w12_rd0_valid", s_out_valid, 1'b1);
        chk("w12_rd0_data", s_out_data, 8'hCD);
        @(negedge clk);
        chk("w12_rd1_valid", s_out_valid, 1'b1);
        chk("w12_rd1_data", s_out_data, 8'h0A);
        @(negedge clk);
        chk("w12_rd_done", s_out_valid, 1'b0);
        s_out_ready = 1'b0;

        // randomized traffic against the model
        for (int t = 0; t < 300; t++) begin
            logic [6:0] a;
            int n;
            a = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(16, 127)) : 7'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                rand_gap();
                send({1'b1, a});
                for (int k = 0; k < NB; k++) begin
                    rand_gap();
                    send(8'($urandom));
                end
            end else begin
                for (int i = 0; i < NREGS; i++) reg_read_values[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                rand_gap();
                send({1'b0, a});
                n = 0;
                while (out_valid && n < 200) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    n++;
                end
                chk("rand_rd_drain", out_valid, 1'b0);
                out_ready = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
